// File: rtl/acondicionador_botones.sv
// Button conditioner for the PicoBlaze keyboard port.
// Synchronises and debounces seven push-buttons and turns each press into a sticky
// event flag that the port decode clears on read. aumenta/disminuye auto-repeat
// while held. A held interrupt request is raised whenever any flag sets.
module acondicionador_botones #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] btn_raw_i,
  input  logic [6:0] flag_clr_i,
  input  logic       interrupt_ack_i,
  output logic [6:0] btn_flag_o,
  output logic [6:0] btn_level_o,
  output logic       interrupcion_o
);

  localparam int unsigned NumBtn = 7;
  localparam int unsigned NumRep = 2;  // only aumenta [0] and disminuye [1] repeat
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DbW-1:0] DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]    DelayLast = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]    PerLast   = 32'(REPEAT_PERIOD - 1);

  // Synchroniser chain
  logic [NumBtn-1:0] sync1_q, sync2_q;

  // Debouncer
  logic [DbW-1:0]    db_cnt_q [NumBtn];
  logic [DbW-1:0]    db_cnt_d [NumBtn];
  logic [NumBtn-1:0] level_q, level_d;
  logic [NumBtn-1:0] level_prev_q;
  logic [NumBtn-1:0] level_rise;

  // Auto-repeat
  logic [31:0]       rep_cnt_q [NumRep];
  logic [31:0]       rep_cnt_d [NumRep];
  logic [NumRep-1:0] rep_first_q, rep_first_d;
  logic [NumRep-1:0] rep_tick;

  // Event flags and interrupt
  logic [NumBtn-1:0] flag_q, flag_d;
  logic [NumBtn-1:0] flag_set;
  logic              irq_q, irq_d;

  // Two-flop synchroniser; only sync2_q is seen by the debouncer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(NumBtn); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounce counters and accepted level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q <= '0;
      for (int i = 0; i < int'(NumBtn); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < int'(NumBtn); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Delayed copy of the level, used to spot the press (0->1) edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_prev_q <= '0;
    end else begin
      level_prev_q <= level_q;
    end
  end

  assign level_rise = level_q & ~level_prev_q;

  // Repeat timers: count from the level rise, fire after REPEAT_DELAY cycles, then
  // every REPEAT_PERIOD cycles; a low level parks the timer at zero immediately.
  always_comb begin
    rep_tick    = '0;
    rep_first_d = rep_first_q;
    for (int i = 0; i < int'(NumRep); i++) begin
      rep_cnt_d[i] = '0;
      if (!level_q[i]) begin
        rep_first_d[i] = 1'b1;
      end else if (rep_cnt_q[i] == (rep_first_q[i] ? DelayLast : PerLast)) begin
        rep_tick[i]    = 1'b1;
        rep_first_d[i] = 1'b0;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + 32'd1;
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rep_first_q <= '1;
      for (int i = 0; i < int'(NumRep); i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_first_q <= rep_first_d;
      for (int i = 0; i < int'(NumRep); i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  // Flags: set beats clear so an event is never lost; interrupt latches on any
  // flag rising and a simultaneous ack cannot swallow it.
  always_comb begin
    flag_set = level_rise | {{(NumBtn - NumRep){1'b0}}, rep_tick};
    flag_d   = flag_set | (flag_q & ~flag_clr_i);
    if (|(flag_d & ~flag_q)) begin
      irq_d = 1'b1;
    end else begin
      irq_d = irq_q & ~interrupt_ack_i;
    end
  end

  // Flag and interrupt registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= irq_d;
    end
  end

  assign btn_flag_o     = flag_q;
  assign btn_level_o    = level_q;
  assign interrupcion_o = irq_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: directed scenarios plus random button traffic,
// checked every cycle against a timestamp-based reference model via a scoreboard.
module tb_acondicionador_botones;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] btn_raw = '0;
  logic [6:0] flag_clr = '0;
  logic       interrupt_ack = 1'b0;
  logic [6:0] btn_flag, btn_level;
  logic       interrupcion;

  acondicionador_botones #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .btn_raw_i      (btn_raw),
    .flag_clr_i     (flag_clr),
    .interrupt_ack_i(interrupt_ack),
    .btn_flag_o     (btn_flag),
    .btn_level_o    (btn_level),
    .interrupcion_o (interrupcion)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] lvl;
    logic [6:0] flg;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state (values after the latest edge)
  int         edge_n = 0;
  logic [6:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_flg = '0;
  logic       m_irq = 1'b0;
  int         mis_start[7];  // edge at which the current mismatch run began, -1 if none
  int         rise_at[7];    // edge at which the level last rose, negative if none

  // Advance the model by one clock edge with the inputs sampled on that edge.
  task automatic model_edge(input logic rst, input logic [6:0] raw, input logic [6:0] clr,
                            input logic ack);
    logic [6:0] set;
    logic [6:0] nlvl;
    logic [6:0] nflg;
    int         age;
    edge_n++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_flg = '0; m_irq = 1'b0;
      for (int b = 0; b < 7; b++) begin
        mis_start[b] = -1;
        rise_at[b]   = -1000000;
      end
    end else begin
      set  = '0;
      nlvl = m_lvl;
      for (int b = 0; b < 7; b++) begin
        if (rise_at[b] == edge_n - 1) set[b] = 1'b1;
        if (b < 2 && m_lvl[b] && rise_at[b] >= 0) begin
          age = edge_n - rise_at[b];
          if (age == RD || (age > RD && (age - RD) % RP == 0)) set[b] = 1'b1;
        end
        if (m_s2[b] == m_lvl[b]) begin
          mis_start[b] = -1;
        end else begin
          if (mis_start[b] < 0) mis_start[b] = edge_n;
          if (edge_n - mis_start[b] + 1 == D) begin
            nlvl[b]      = m_s2[b];
            mis_start[b] = -1;
            if (m_s2[b]) rise_at[b] = edge_n;
          end
        end
      end
      nflg  = set | (m_flg & ~clr);
      m_irq = (|(nflg & ~m_flg)) ? 1'b1 : (m_irq & ~ack);
      m_s2  = m_s1;
      m_s1  = raw;
      m_lvl = nlvl;
      m_flg = nflg;
    end
    exp_q.push_back('{lvl: m_lvl, flg: m_flg, irq: m_irq});
  endtask

  task automatic step(input logic rst, input logic [6:0] raw, input logic [6:0] clr,
                      input logic ack);
    reset         = rst;
    btn_raw       = raw;
    flag_clr      = clr;
    interrupt_ack = ack;
    @(posedge clk);
    model_edge(rst, raw, clr, ack);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest expectation, away from the edge.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (btn_level !== mon_e.lvl) begin
        fails++;
        $display("FAIL btn_level edge %0d: got %h, expected %h", edge_n, btn_level, mon_e.lvl);
      end
      tests++;
      if (btn_flag !== mon_e.flg) begin
        fails++;
        $display("FAIL btn_flag edge %0d: got %h, expected %h", edge_n, btn_flag, mon_e.flg);
      end
      tests++;
      if (interrupcion !== mon_e.irq) begin
        fails++;
        $display("FAIL interrupcion edge %0d: got %b, expected %b", edge_n, interrupcion,
                 mon_e.irq);
      end
    end
  end

  logic [6:0] raw_v, clr_v;
  int         hold_left[7];

  initial begin
    for (int b = 0; b < 7; b++) begin
      mis_start[b] = -1;
      rise_at[b]   = -1000000;
      hold_left[b] = 0;
    end

    // Reset with every pin high
    step(1'b1, 7'h7F, '0, 1'b0);
    step(1'b1, 7'h7F, '0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b0);

    // Clean press on siguiente, then acknowledge and clear
    for (int c = 0; c < 10; c++) step(1'b0, 7'h04, '0, 1'b0);
    step(1'b0, 7'h04, 7'h04, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b0);

    // Bounce on cambia: never stable for D cycles
    for (int c = 0; c < 3; c++) step(1'b0, 7'h20, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 7'h20, '0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b0);

    // Hold aumenta and anterior, clearing flags as soon as they show
    for (int c = 0; c < 100; c++) step(1'b0, 7'h09, m_flg & 7'h09, m_irq);
    for (int c = 0; c < 40; c++) step(1'b0, '0, m_flg, m_irq);

    // Collisions: clear and ack held while disminuye presses and repeats
    for (int c = 0; c < 40; c++) step(1'b0, 7'h02, 7'h02, 1'b1);
    for (int c = 0; c < 15; c++) step(1'b0, '0, '0, 1'b0);

    // Reset in mid-debounce while formato stays high
    for (int c = 0; c < 4; c++) step(1'b0, 7'h10, '0, 1'b0);
    step(1'b1, 7'h10, '0, 1'b0);
    for (int c = 0; c < 12; c++) step(1'b0, 7'h10, '0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, '0, 7'h7F, 1'b1);

    // Random traffic with held levels of random length
    raw_v = '0;
    for (int c = 0; c < 1500; c++) begin
      clr_v = '0;
      for (int b = 0; b < 7; b++) begin
        if (hold_left[b] == 0) begin
          raw_v[b]     = 1'($urandom_range(0, 1));
          hold_left[b] = int'($urandom_range(1, 45));
        end else begin
          hold_left[b]--;
        end
        if ($urandom_range(0, 5) == 0) clr_v[b] = 1'b1;
      end
      step($urandom_range(0, 399) == 0, raw_v, clr_v, $urandom_range(0, 3) == 0);
    end

    step(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
